// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/sub datapath: default field
// widths, guard/round/sticky width and the alignment FSM encoding.
package fpu_pkg;

  localparam int EXPONENT_SIZE = 8;
  localparam int MANTISSA_SIZE = 23;
  localparam int GRS_WIDTH     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alignState_t;

endpackage

// File: rtl/exponent_compare.sv
// Combinational operand ordering: picks the larger operand (exponent first,
// mantissa as tie-break) and returns its exponent and the exponent distance.
module exponent_compare
  import fpu_pkg::*;
#(
  parameter int ExponentSize = EXPONENT_SIZE,
  parameter int MantissaSize = MANTISSA_SIZE
) (
  input  logic [ExponentSize-1:0] exponentA,
  input  logic [ExponentSize-1:0] exponentB,
  input  logic [MantissaSize:0]   mantissaA,
  input  logic [MantissaSize:0]   mantissaB,
  output logic                    swapped,
  output logic [ExponentSize-1:0] exponentLarge,
  output logic [ExponentSize-1:0] exponentDiff
);

  logic aIsLarger;

  // Equal operands keep A as the larger one, so Swapped stays 0 on a tie.
  assign aIsLarger = (exponentA > exponentB) ||
                     ((exponentA == exponentB) && (mantissaA >= mantissaB));

  assign swapped       = ~aIsLarger;
  assign exponentLarge = aIsLarger ? exponentA : exponentB;
  assign exponentDiff  = aIsLarger ? (exponentA - exponentB) : (exponentB - exponentA);

endmodule

// File: rtl/exponent_align.sv
// Pre-add alignment: orders the operands, then shifts the smaller mantissa
// right one bit per clock, folding shifted-out bits into guard/round/sticky.
module exponent_align
  import fpu_pkg::*;
#(
  parameter int ExponentSize = EXPONENT_SIZE,
  parameter int MantissaSize = MANTISSA_SIZE
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             InValid,
  output logic                             InReady,
  input  logic [ExponentSize-1:0]          ExponentA,
  input  logic [ExponentSize-1:0]          ExponentB,
  input  logic [MantissaSize:0]            MantissaA,
  input  logic [MantissaSize:0]            MantissaB,
  output logic                             OutValid,
  input  logic                             OutReady,
  output logic [ExponentSize-1:0]          OutExponent,
  output logic [MantissaSize+GRS_WIDTH:0]  OutMantissaLarge,
  output logic [MantissaSize+GRS_WIDTH:0]  OutMantissaSmall,
  output logic                             Swapped
);

  localparam int AlignWidth = MantissaSize + 1 + GRS_WIDTH;
  localparam logic [ExponentSize-1:0] SaturateShift = ExponentSize'(AlignWidth - 1);

  alignState_t state, nextState;

  logic                    selSwapped;
  logic [ExponentSize-1:0] selExponent;
  logic [ExponentSize-1:0] expDiff;
  logic [MantissaSize:0]   mantLarge;
  logic [MantissaSize:0]   mantSmall;
  logic                    accept;
  logic                    saturate;
  logic [ExponentSize-1:0] shiftCount;
  logic [AlignWidth-1:0]   smallReg;

  exponent_compare #(
    .ExponentSize (ExponentSize),
    .MantissaSize (MantissaSize)
  ) compareInst (
    .exponentA     (ExponentA),
    .exponentB     (ExponentB),
    .mantissaA     (MantissaA),
    .mantissaB     (MantissaB),
    .swapped       (selSwapped),
    .exponentLarge (selExponent),
    .exponentDiff  (expDiff)
  );

  assign mantLarge = selSwapped ? MantissaB : MantissaA;
  assign mantSmall = selSwapped ? MantissaA : MantissaB;
  assign InReady   = (state == IDLE);
  assign OutValid  = (state == DONE);
  assign accept    = InValid && InReady;
  // Any distance that would push the whole mantissa past the sticky bit
  // collapses to a single sticky bit in one step.
  assign saturate  = (expDiff >= SaturateShift);
  assign OutMantissaSmall = smallReg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((expDiff == '0) || saturate) nextState = DONE;
          else                             nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (shiftCount == ExponentSize'(1)) nextState = DONE;
      end
      DONE: begin
        if (OutReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutExponent      <= '0;
      OutMantissaLarge <= '0;
      smallReg         <= '0;
      Swapped          <= 1'b0;
      shiftCount       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            OutExponent      <= selExponent;
            OutMantissaLarge <= {mantLarge, {GRS_WIDTH{1'b0}}};
            Swapped          <= selSwapped;
            shiftCount       <= expDiff;
            if (saturate) smallReg <= {{(AlignWidth-1){1'b0}}, |mantSmall};
            else          smallReg <= {mantSmall, {GRS_WIDTH{1'b0}}};
          end
        end
        SHIFT: begin
          // Bit 0 absorbs whatever falls off the end, so sticky never clears.
          smallReg   <= {1'b0, smallReg[AlignWidth-1:2], smallReg[1] | smallReg[0]};
          shiftCount <= shiftCount - ExponentSize'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exponent_align.sv
// Directed bench for exponent_align: hand-computed vectors for shift, swap,
// sticky, equal exponents, saturation, backpressure and asynchronous reset.
module tb_exponent_align;
  import fpu_pkg::*;

  localparam int ES = 8;
  localparam int MS = 23;
  localparam int W  = MS + 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [ES-1:0] ExponentA, ExponentB;
  logic [MS:0]   MantissaA, MantissaB;
  logic          OutValid;
  logic          OutReady;
  logic [ES-1:0] OutExponent;
  logic [W-1:0]  OutMantissaLarge;
  logic [W-1:0]  OutMantissaSmall;
  logic          Swapped;

  int testCount = 0;
  int failCount = 0;
  int lat;

  exponent_align #(.ExponentSize(ES), .MantissaSize(MS)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .InValid          (InValid),
    .InReady          (InReady),
    .ExponentA        (ExponentA),
    .ExponentB        (ExponentB),
    .MantissaA        (MantissaA),
    .MantissaB        (MantissaB),
    .OutValid         (OutValid),
    .OutReady         (OutReady),
    .OutExponent      (OutExponent),
    .OutMantissaLarge (OutMantissaLarge),
    .OutMantissaSmall (OutMantissaSmall),
    .Swapped          (Swapped)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair for exactly one accept edge, then scrambles the
  // inputs; returns #1 after the accept edge.
  task automatic startOp(input logic [ES-1:0] ea, input logic [ES-1:0] eb,
                         input logic [MS:0] ma, input logic [MS:0] mb);
    int n = 0;
    while (!InReady && n < 64) begin
      @(posedge Clk); #1; n++;
    end
    if (!InReady) check("inReadyWait", 64'(InReady), 64'd1);
    InValid = 1'b1; ExponentA = ea; ExponentB = eb; MantissaA = ma; MantissaB = mb;
    @(posedge Clk); #1;
    InValid   = 1'b0;
    ExponentA = ES'($urandom); ExponentB = ES'($urandom);
    MantissaA = (MS+1)'($urandom); MantissaB = (MS+1)'($urandom);
  endtask

  // Edges after the accept edge until OutValid; 0 means visible straight
  // after the accept edge (the single-edge cases).
  task automatic waitValid(input string tag, input int expLat);
    lat = 0;
    while (!OutValid && lat < 100) begin
      @(posedge Clk); #1; lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(expLat));
  endtask

  task automatic checkResult(input string tag, input logic [ES-1:0] expE,
                             input logic [W-1:0] expL, input logic [W-1:0] expS,
                             input logic expSw);
    check({tag, "_valid"},   64'(OutValid),         64'd1);
    check({tag, "_exp"},     64'(OutExponent),      64'(expE));
    check({tag, "_large"},   64'(OutMantissaLarge), 64'(expL));
    check({tag, "_small"},   64'(OutMantissaSmall), 64'(expS));
    check({tag, "_swapped"}, 64'(Swapped),          64'(expSw));
  endtask

  task automatic takeResult(input string tag);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check({tag, "_validDrop"}, 64'(OutValid), 64'd0);
    check({tag, "_inReady"},   64'(InReady),  64'd1);
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    ExponentA = '0; ExponentB = '0; MantissaA = '0; MantissaB = '0;
    #1;
    check("rst_valid",   64'(OutValid),         64'd0);
    check("rst_exp",     64'(OutExponent),      64'd0);
    check("rst_large",   64'(OutMantissaLarge), 64'd0);
    check("rst_small",   64'(OutMantissaSmall), 64'd0);
    check("rst_swapped", 64'(Swapped),          64'd0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    #1 check("rst_inReady", 64'(InReady), 64'd1);

    // d=2, A larger
    startOp(8'd130, 8'd128, 24'h800000, 24'hC00000);
    check("shift_busy", 64'(InReady), 64'd0);
    waitValid("shift", 2);
    checkResult("shift", 8'd130, 27'h4000000, 27'h1800000, 1'b0);

    // Backpressure: result held, new operands ignored
    InValid = 1'b1; ExponentA = 8'd10; ExponentB = 8'd200;
    MantissaA = 24'hFFFFFF; MantissaB = 24'h812345;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("bp_valid",   64'(OutValid),         64'd1);
      check("bp_inReady", 64'(InReady),          64'd0);
      check("bp_small",   64'(OutMantissaSmall), 64'h1800000);
    end
    InValid = 1'b0;
    checkResult("bp_hold", 8'd130, 27'h4000000, 27'h1800000, 1'b0);
    takeResult("bp");

    // d=5, B larger; A's low bit lands in sticky
    startOp(8'd100, 8'd105, 24'h800001, 24'h800000);
    waitValid("swap", 5);
    checkResult("swap", 8'd105, 27'h4000000, 27'h0200001, 1'b1);
    takeResult("swap");

    // Equal exponents, mantissa decides
    startOp(8'd127, 8'd127, 24'h900000, 24'hA00000);
    waitValid("equal", 0);
    checkResult("equal", 8'd127, 27'h5000000, 27'h4800000, 1'b1);
    takeResult("equal");

    // Identical operands keep A as larger
    startOp(8'd90, 8'd90, 24'hABCDEF, 24'hABCDEF);
    waitValid("tie", 0);
    checkResult("tie", 8'd90, 27'h55E6F78, 27'h55E6F78, 1'b0);
    takeResult("tie");

    // Saturation at d=32 and at the threshold d=26
    startOp(8'd160, 8'd128, 24'h800000, 24'h800000);
    waitValid("sat32", 0);
    checkResult("sat32", 8'd160, 27'h4000000, 27'h0000001, 1'b0);
    takeResult("sat32");
    startOp(8'd154, 8'd128, 24'h800000, 24'h800000);
    waitValid("sat26", 0);
    checkResult("sat26", 8'd154, 27'h4000000, 27'h0000001, 1'b0);
    takeResult("sat26");

    // d=25, longest real shift: 0x4000008 >> 25 = 2, sticky from bit 3
    startOp(8'd153, 8'd128, 24'h800000, 24'h800001);
    waitValid("d25", 25);
    checkResult("d25", 8'd153, 27'h4000000, 27'h0000003, 1'b0);
    takeResult("d25");

    // Asynchronous reset in the middle of a d=10 shift
    startOp(8'd140, 8'd130, 24'hF00000, 24'hFFFFFF);
    repeat (4) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("arst_valid", 64'(OutValid),         64'd0);
    check("arst_exp",   64'(OutExponent),      64'd0);
    check("arst_large", 64'(OutMantissaLarge), 64'd0);
    check("arst_small", 64'(OutMantissaSmall), 64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1 check("arst_inReady", 64'(InReady), 64'd1);

    // Fresh operation after reset, d=3
    startOp(8'd50, 8'd53, 24'hC00000, 24'h900000);
    waitValid("post", 3);
    checkResult("post", 8'd53, 27'h4800000, 27'h0C00000, 1'b1);
    takeResult("post");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
